// File: rtl/imem_ecc_responder.sv
// Purpose : ECC instruction-memory responder. Stores 39-bit codewords, serves reads and rewrite-path writes, XORs fault masks into stored words.
// Latency : IRDATA is registered and valid the cycle after accept; nIWAIT then stays low for WAIT_CYC cycles.
// Backpr. : a request is accepted only while nIWAIT=1; the requester holds IREQ/IADDR/IRW/IWDATA stable while nIWAIT=0.
//
// Ports:
//   gCLK, RST            clock, synchronous active-high reset
//   IREQ/IADDR/IRW/IWDATA request (IRW: 0 = read, 1 = write); only IADDR[DEPTH_LOG2-1:0] is decoded
//   IRDATA, nIWAIT       registered read codeword, ready/stall (1 = ready)
//   INJ_EN/ADDR/MASK     fault-inject strobe; XORs INJ_MASK into the stored word
//   RD_CNT, WR_CNT       accepted read/write counts, wrap at 2^16
module imem_ecc_responder #(
    parameter int DEPTH_LOG2 = 10,
    parameter int WAIT_CYC   = 0
) (
    input  logic        gCLK,
    input  logic        RST,
    input  logic        IREQ,
    input  logic [29:0] IADDR,
    input  logic        IRW,
    input  logic [38:0] IWDATA,
    output logic [38:0] IRDATA,
    output logic        nIWAIT,
    input  logic        INJ_EN,
    input  logic [29:0] INJ_ADDR,
    input  logic [38:0] INJ_MASK,
    output logic [15:0] RD_CNT,
    output logic [15:0] WR_CNT
);

    localparam int         DEPTH  = 1 << DEPTH_LOG2;
    localparam logic [3:0] WAIT_N = 4'(WAIT_CYC);

    typedef enum logic {
        ST_RDY  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t                state, state_nx;
    logic [3:0]            cnt, cnt_nx;
    logic [38:0]           mem [DEPTH];
    logic [DEPTH_LOG2-1:0] acc_addr;
    logic [DEPTH_LOG2-1:0] inj_addr_a;
    logic                  accept;
    logic                  wr_accept;
    logic                  inj_act;
    logic                  inj_hit;
    logic                  inj_only;
    logic                  unused_addr_bits;

    // Upper address bits alias onto the array.
    assign acc_addr         = IADDR[DEPTH_LOG2-1:0];
    assign inj_addr_a       = INJ_ADDR[DEPTH_LOG2-1:0];
    assign unused_addr_bits = ^{IADDR[29:DEPTH_LOG2], INJ_ADDR[29:DEPTH_LOG2]};

    // Reset suppresses both accepts and injections at its edge.
    assign accept    = !RST && IREQ && (state == ST_RDY);
    assign wr_accept = accept && IRW;
    assign inj_act   = !RST && INJ_EN;
    // An injection landing on the word being written merges into that single write.
    assign inj_hit   = inj_act && wr_accept && (inj_addr_a == acc_addr);
    assign inj_only  = inj_act && !inj_hit;

    // Ready is purely a function of registered state.
    assign nIWAIT = (state == ST_RDY);

    always_ff @(posedge gCLK) begin
        if (RST) begin
            state <= ST_RDY;
            cnt   <= 4'd0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
        end
    end

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        case (state)
            ST_RDY: begin
                if (accept && (WAIT_N != 4'd0)) begin
                    state_nx = ST_WAIT;
                    cnt_nx   = WAIT_N;
                end
            end
            ST_WAIT: begin
                cnt_nx = cnt - 4'd1;
                // <= 1 rather than == 1 so a corrupted zero count cannot lock the stall.
                if (cnt <= 4'd1) begin
                    state_nx = ST_RDY;
                end
            end
            default: begin
                state_nx = ST_RDY;
            end
        endcase
    end

    // Response data and counters. Reads sample mem before this edge's injection lands.
    always_ff @(posedge gCLK) begin
        if (RST) begin
            IRDATA <= 39'd0;
            RD_CNT <= 16'd0;
            WR_CNT <= 16'd0;
        end else if (accept) begin
            if (IRW) begin
                IRDATA <= IWDATA;
                WR_CNT <= WR_CNT + 16'd1;
            end else begin
                IRDATA <= mem[acc_addr];
                RD_CNT <= RD_CNT + 16'd1;
            end
        end
    end

    // Storage is never reset; contents are established by writes.
    always_ff @(posedge gCLK) begin
        if (wr_accept) begin
            mem[acc_addr] <= inj_hit ? (IWDATA ^ INJ_MASK) : IWDATA;
        end
        if (inj_only) begin
            mem[inj_addr_a] <= mem[inj_addr_a] ^ INJ_MASK;
        end
    end

endmodule

// File: tb/tb_imem_ecc_responder.sv
module tb_imem_ecc_responder;

    logic        gCLK;
    logic        rst;
    logic [2:0]  ireq;
    logic [29:0] iaddr;
    logic        irw;
    logic [38:0] iwdata;
    logic        inj_en;
    logic [29:0] inj_addr;
    logic [38:0] inj_mask;
    logic [38:0] irdata [3];
    logic [2:0]  n_iwait;
    logic [15:0] rd_cnt [3];
    logic [15:0] wr_cnt [3];

    int checks   = 0;
    int failures = 0;

    // Three instances with different stall lengths share one stimulus stream;
    // each has its own IREQ so every DUT sees exactly one accept per transaction.
    int waits [3] = '{0, 3, 5};

    // Reference model: per DUT, remaining stall cycles plus a plain word array.
    int          busy  [3];
    logic [38:0] m_mem [3][1024];
    logic [38:0] m_ird [3];
    logic [15:0] m_rd  [3];
    logic [15:0] m_wr  [3];
    logic [2:0]  acc;

    string t_ird [3] = '{"ird_w0", "ird_w3", "ird_w5"};
    string t_nw  [3] = '{"nwait_w0", "nwait_w3", "nwait_w5"};
    string t_rd  [3] = '{"rdcnt_w0", "rdcnt_w3", "rdcnt_w5"};
    string t_wr  [3] = '{"wrcnt_w0", "wrcnt_w3", "wrcnt_w5"};

    imem_ecc_responder #(.DEPTH_LOG2(10), .WAIT_CYC(0)) u_dut0 (
        .gCLK(gCLK), .RST(rst), .IREQ(ireq[0]), .IADDR(iaddr), .IRW(irw), .IWDATA(iwdata),
        .IRDATA(irdata[0]), .nIWAIT(n_iwait[0]), .INJ_EN(inj_en), .INJ_ADDR(inj_addr),
        .INJ_MASK(inj_mask), .RD_CNT(rd_cnt[0]), .WR_CNT(wr_cnt[0])
    );
    imem_ecc_responder #(.DEPTH_LOG2(10), .WAIT_CYC(3)) u_dut3 (
        .gCLK(gCLK), .RST(rst), .IREQ(ireq[1]), .IADDR(iaddr), .IRW(irw), .IWDATA(iwdata),
        .IRDATA(irdata[1]), .nIWAIT(n_iwait[1]), .INJ_EN(inj_en), .INJ_ADDR(inj_addr),
        .INJ_MASK(inj_mask), .RD_CNT(rd_cnt[1]), .WR_CNT(wr_cnt[1])
    );
    imem_ecc_responder #(.DEPTH_LOG2(10), .WAIT_CYC(5)) u_dut5 (
        .gCLK(gCLK), .RST(rst), .IREQ(ireq[2]), .IADDR(iaddr), .IRW(irw), .IWDATA(iwdata),
        .IRDATA(irdata[2]), .nIWAIT(n_iwait[2]), .INJ_EN(inj_en), .INJ_ADDR(inj_addr),
        .INJ_MASK(inj_mask), .RD_CNT(rd_cnt[2]), .WR_CNT(wr_cnt[2])
    );

    initial begin
        gCLK = 1'b0;
        forever #5 gCLK = ~gCLK;
    end

    task automatic chk(input string tag, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h", tag, act, exp);
        end
    endtask

    // Advance the reference model by one rising edge using the driven inputs.
    task automatic model_step();
        for (int i = 0; i < 3; i++) begin
            acc[i] = 1'b0;
            if (rst) begin
                busy[i]  = 0;
                m_ird[i] = '0;
                m_rd[i]  = '0;
                m_wr[i]  = '0;
            end else begin
                if (ireq[i] && busy[i] == 0) begin
                    acc[i] = 1'b1;
                    if (irw) begin
                        m_ird[i]              = iwdata;
                        m_mem[i][iaddr[9:0]] = iwdata;
                        m_wr[i]               = m_wr[i] + 16'd1;
                    end else begin
                        m_ird[i] = m_mem[i][iaddr[9:0]];
                        m_rd[i]  = m_rd[i] + 16'd1;
                    end
                    busy[i] = waits[i];
                end else if (busy[i] > 0) begin
                    busy[i] = busy[i] - 1;
                end
                if (inj_en) begin
                    m_mem[i][inj_addr[9:0]] = m_mem[i][inj_addr[9:0]] ^ inj_mask;
                end
            end
        end
    endtask

    // One clock: model follows the edge, DUT outputs compared at the falling edge.
    task automatic cyc();
        @(posedge gCLK);
        model_step();
        @(negedge gCLK);
        for (int i = 0; i < 3; i++) begin
            chk(t_ird[i], 64'(irdata[i]), 64'(m_ird[i]));
            chk(t_nw[i],  64'(n_iwait[i]), 64'(busy[i] == 0));
            chk(t_rd[i],  64'(rd_cnt[i]), 64'(m_rd[i]));
            chk(t_wr[i],  64'(wr_cnt[i]), 64'(m_wr[i]));
        end
    endtask

    task automatic idle_wait();
        ireq = 3'b000;
        for (int n = 0; n < 20 && (busy[0] != 0 || busy[1] != 0 || busy[2] != 0); n++) begin
            cyc();
        end
    endtask

    // One access to every DUT (optionally with an injection on the first edge).
    task automatic xact(input logic do_req, input logic rw, input logic [29:0] addr,
                        input logic [38:0] wd, input logic ie, input logic [29:0] ia,
                        input logic [38:0] im);
        logic [2:0] done;
        idle_wait();
        irw      = rw;
        iaddr    = addr;
        iwdata   = wd;
        inj_en   = ie;
        inj_addr = ia;
        inj_mask = im;
        done     = do_req ? 3'b000 : 3'b111;
        for (int n = 0; n < 20 && (n == 0 || done != 3'b111); n++) begin
            ireq = do_req ? ~done : 3'b000;
            cyc();
            done   = done | acc;
            inj_en = 1'b0;
        end
        ireq = 3'b000;
        chk("xact_done", 64'(done), 64'h7);
    endtask

    task automatic wr(input logic [29:0] a, input logic [38:0] d);
        xact(1'b1, 1'b1, a, d, 1'b0, '0, '0);
    endtask

    task automatic rd(input logic [29:0] a);
        xact(1'b1, 1'b0, a, '0, 1'b0, '0, '0);
    endtask

    task automatic inj(input logic [29:0] a, input logic [38:0] m);
        xact(1'b0, 1'b0, '0, '0, 1'b1, a, m);
    endtask

    task automatic reset_cycle();
        rst = 1'b1;
        cyc();
        rst = 1'b0;
    endtask

    function automatic logic [29:0] rnd_addr();
        logic [29:0] a;
        a      = 30'($urandom()) & 30'h3FFF_FC00;
        a[3:0] = 4'($urandom_range(0, 15));
        return a;
    endfunction

    initial begin
        logic [29:0] a;
        logic [38:0] d;
        int          r;

        rst      = 1'b1;
        ireq     = 3'b000;
        iaddr    = '0;
        irw      = 1'b0;
        iwdata   = '0;
        inj_en   = 1'b0;
        inj_addr = '0;
        inj_mask = '0;
        for (int i = 0; i < 3; i++) begin
            busy[i] = 0;
        end

        // Reset values
        reset_cycle();
        chk("rst_ird",   64'(irdata[0]), 64'h0);
        chk("rst_nwait", 64'(n_iwait),   64'h7);
        chk("rst_rdcnt", 64'(rd_cnt[2]), 64'h0);
        chk("rst_wrcnt", 64'(wr_cnt[1]), 64'h0);

        // Write then read back
        wr(30'd5, 39'h12_3456_789A);
        rd(30'd5);
        for (int i = 0; i < 3; i++) begin
            chk("wr_rd_data", 64'(irdata[i]), 64'h12_3456_789A);
            chk("wr_rd_cnts", {32'(rd_cnt[i]), 32'(wr_cnt[i])}, {32'd1, 32'd1});
        end
        chk("wr_rd_nwait0", 64'(n_iwait[0]), 64'h1);

        // Stall timing on the WAIT_CYC=3 instance, second request held during the stall
        wr(30'd7, 39'h0F);
        idle_wait();
        irw   = 1'b0;
        iaddr = 30'd7;
        ireq  = 3'b010;
        cyc();
        chk("w3_k1_nwait", 64'(n_iwait[1]), 64'h0);
        chk("w3_k1_ird",   64'(irdata[1]),  64'h0F);
        cyc();
        chk("w3_k2_nwait", 64'(n_iwait[1]), 64'h0);
        cyc();
        chk("w3_k3_nwait", 64'(n_iwait[1]), 64'h0);
        chk("w3_k3_rdcnt", 64'(rd_cnt[1]),  64'd2);
        cyc();
        chk("w3_k4_nwait", 64'(n_iwait[1]), 64'h1);
        chk("w3_k4_rdcnt", 64'(rd_cnt[1]),  64'd2);
        chk("w3_k4_ird",   64'(irdata[1]),  64'h0F);
        cyc();
        chk("w3_k5_rdcnt", 64'(rd_cnt[1]),  64'd3);
        chk("w3_k5_nwait", 64'(n_iwait[1]), 64'h0);
        ireq = 3'b000;

        // Fault injection toggles a stored bit
        wr(30'd2, 39'h0);
        inj(30'd2, 39'h1);
        rd(30'd2);
        for (int i = 0; i < 3; i++) chk("inj_once", 64'(irdata[i]), 64'h1);
        inj(30'd2, 39'h1);
        rd(30'd2);
        for (int i = 0; i < 3; i++) chk("inj_twice", 64'(irdata[i]), 64'h0);

        // Injection colliding with a write on the same edge
        xact(1'b1, 1'b1, 30'd9, 39'hAA, 1'b1, 30'd9, 39'h100);
        for (int i = 0; i < 3; i++) chk("coll_ird", 64'(irdata[i]), 64'hAA);
        rd(30'd9);
        for (int i = 0; i < 3; i++) chk("coll_mem", 64'(irdata[i]), 64'h1AA);

        // Address aliasing
        wr(30'h400, 39'h55);
        rd(30'h000);
        for (int i = 0; i < 3; i++) chk("alias", 64'(irdata[i]), 64'h55);

        // Reset in the 2nd stall cycle of the WAIT_CYC=5 instance
        idle_wait();
        irw   = 1'b0;
        iaddr = 30'd9;
        ireq  = 3'b100;
        cyc();
        ireq  = 3'b000;
        cyc();
        reset_cycle();
        chk("midrst_nwait", 64'(n_iwait[2]), 64'h1);
        chk("midrst_ird",   64'(irdata[2]),  64'h0);
        chk("midrst_cnts",  {32'(rd_cnt[2]), 32'(wr_cnt[2])}, 64'h0);
        rd(30'd5);
        for (int i = 0; i < 3; i++) chk("midrst_keep", 64'(irdata[i]), 64'h12_3456_789A);

        // Randomized traffic over a preloaded 16-word pool with aliased upper bits
        for (int k = 0; k < 16; k++) begin
            wr(30'(k), 39'({$urandom(), $urandom()}));
        end
        for (int k = 0; k < 600; k++) begin
            r = int'($urandom_range(0, 9));
            a = rnd_addr();
            d = 39'({$urandom(), $urandom()});
            if (r <= 3) begin
                xact(1'b1, 1'b0, a, '0, ($urandom_range(0, 3) == 0),
                     ($urandom_range(0, 1) == 0) ? a : rnd_addr(), 39'({$urandom(), $urandom()}));
            end else if (r <= 6) begin
                wr(a, d);
            end else if (r == 7) begin
                inj(a, 39'({$urandom(), $urandom()}));
            end else if (r == 8) begin
                xact(1'b1, 1'b1, a, d, 1'b1, {rnd_addr()} & 30'h3FFF_FC00 | 30'(a[3:0]),
                     39'({$urandom(), $urandom()}));
            end else if ($urandom_range(0, 3) == 0) begin
                reset_cycle();
            end else begin
                cyc();
            end
        end

        // Read counter wrap on the zero-wait instance
        idle_wait();
        reset_cycle();
        irw   = 1'b0;
        iaddr = 30'd3;
        ireq  = 3'b111;
        for (int k = 0; k < 65535; k++) begin
            cyc();
        end
        chk("rd_wrap_pre", 64'(rd_cnt[0]), 64'hFFFF);
        cyc();
        chk("rd_wrap", 64'(rd_cnt[0]), 64'h0);
        ireq = 3'b000;
        cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
